mem_arbiter: RTL and testbench

Shares one memory port (DataMemory-style: combinational read, write on clk edge, byte/half/word sizing) between the instruction-fetch requester and the data (MEM-stage) requester of the MIPS core. Holds each granted command stable on the memory for a fixed number of cycles, then returns data with a one-cycle ack. Data requests have priority, with an anti-starvation limit for fetch. Misaligned accesses are rejected without touching memory.

---
 rtl/mem_pkg.sv | 40 ++++
 rtl/mem_align_check.sv | 28 ++
 rtl/mem_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared encodings for the data memory port and its arbiter:
//               access sizes, arbiter states, requester ownership and the
//               registered memory command.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Access size encodings on the memory port (00 is illegal).
  localparam logic [1:0] SIZE_NONE = 2'b00;
  localparam logic [1:0] SIZE_BYTE = 2'b01;
  localparam logic [1:0] SIZE_HALF = 2'b10;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  // Arbiter state encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } arb_state_t;

  // Which requester owns the transaction in flight.
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Command captured at grant time and replayed onto the memory port.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sign;
    logic        we;
  } mem_cmd_t;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_align_check.sv
`default_nettype none
// ============================================================================
// Module      : mem_align_check
// Description : Flags an access whose low address bits do not suit its size,
//               or whose size code is illegal. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_align_check
  import mem_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  logic [1:0] size,
  output logic       misaligned
);

  // Bytes are always aligned; halves need bit 0 clear; words need both clear.
  always_comb begin
    misaligned = 1'b0;
    case (size)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = addr_lo[0];
      SIZE_WORD: misaligned = (addr_lo != 2'b00);
      default:   misaligned = 1'b1;
    endcase
  end

endmodule : mem_align_check
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one combinational-read memory port between the fetch
//               and data requesters. Data has priority; fetch is forced to
//               win after STARVE_LIMIT consecutive data grants made while it
//               waited. Each command is held MEM_LATENCY cycles, then a
//               one-cycle ack is returned. Misaligned accesses are acked
//               with an error and never reach the memory.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  // fetch requester
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  output logic        i_err,
  // data requester
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  input  logic        d_sign,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_err,
  // memory port
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_read,
  output logic        m_write,
  output logic [1:0]  m_size,
  output logic        m_sign,
  input  logic [31:0] m_rdata
);

  localparam int c_cnt_w = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int c_stv_w = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(MEM_LATENCY - 1);
  localparam logic [c_stv_w-1:0] c_stv_max  = c_stv_w'(STARVE_LIMIT);

  arb_state_t           r_state;
  arb_state_t           w_next_state;
  owner_t               r_owner;
  mem_cmd_t             r_cmd;
  logic                 r_err;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_stv_w-1:0]   r_starve;
  logic [31:0]          r_i_rdata;
  logic [31:0]          r_d_rdata;

  logic                 w_i_mis;
  logic                 w_d_mis;
  logic                 w_starved;
  logic                 w_grant_i;
  logic                 w_grant_d;
  logic                 w_last;
  mem_cmd_t             w_i_cmd;
  mem_cmd_t             w_d_cmd;

  // Fetches are always word reads, so only the address needs checking.
  mem_align_check u_align_i (
    .addr_lo    (i_addr[1:0]),
    .size       (SIZE_WORD),
    .misaligned (w_i_mis)
  );

  mem_align_check u_align_d (
    .addr_lo    (d_addr[1:0]),
    .size       (d_size),
    .misaligned (w_d_mis)
  );

  // Arbitration: data first unless fetch has been passed over too often.
  always_comb begin
    w_starved = (r_starve >= c_stv_max);
    w_grant_i = (r_state == IDLE) && i_req && (!d_req || w_starved);
    w_grant_d = (r_state == IDLE) && d_req && !w_grant_i;
    w_last    = (r_cnt == c_cnt_last);
  end

  // Commands as they will be registered for each requester.
  always_comb begin
    w_i_cmd       = '0;
    w_i_cmd.addr  = i_addr;
    w_i_cmd.size  = SIZE_WORD;
    w_d_cmd       = '0;
    w_d_cmd.addr  = d_addr;
    w_d_cmd.wdata = d_we ? d_wdata : 32'h0;
    w_d_cmd.size  = d_size;
    w_d_cmd.sign  = d_sign;
    w_d_cmd.we    = d_we;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and all port outputs; memory is only driven while BUSY.
  always_comb begin
    w_next_state = r_state;
    m_addr       = 32'h0;
    m_wdata      = 32'h0;
    m_read       = 1'b0;
    m_write      = 1'b0;
    m_size       = 2'b00;
    m_sign       = 1'b0;
    i_ack        = 1'b0;
    i_err        = 1'b0;
    d_ack        = 1'b0;
    d_err        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_i) begin
          w_next_state = w_i_mis ? ACK : BUSY;
        end else if (w_grant_d) begin
          w_next_state = w_d_mis ? ACK : BUSY;
        end
      end
      BUSY: begin
        m_addr  = r_cmd.addr;
        m_wdata = r_cmd.wdata;
        m_size  = r_cmd.size;
        m_sign  = r_cmd.sign;
        m_read  = !r_cmd.we;
        // A store commits only on the final hold cycle, once the address
        // and data have been stable on the port.
        m_write = r_cmd.we && w_last;
        if (w_last) begin
          w_next_state = ACK;
        end
      end
      ACK: begin
        i_ack        = (r_owner == OWN_I);
        i_err        = (r_owner == OWN_I) && r_err;
        d_ack        = (r_owner == OWN_D);
        d_err        = (r_owner == OWN_D) && r_err;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Command capture at grant, hold counter, starvation count, read capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner   <= OWN_I;
      r_cmd     <= '0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
      r_starve  <= '0;
      r_i_rdata <= 32'h0;
      r_d_rdata <= 32'h0;
    end else begin
      if (w_grant_i) begin
        r_owner  <= OWN_I;
        r_cmd    <= w_i_cmd;
        r_err    <= w_i_mis;
        r_cnt    <= '0;
        r_starve <= '0;
      end else if (w_grant_d) begin
        r_owner <= OWN_D;
        r_cmd   <= w_d_cmd;
        r_err   <= w_d_mis;
        r_cnt   <= '0;
        // Count only grants that actually made fetch wait.
        if (i_req && (r_starve < c_stv_max)) begin
          r_starve <= r_starve + 1'b1;
        end
      end
      if (r_state == BUSY) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_last && !r_cmd.we) begin
          if (r_owner == OWN_I) begin
            r_i_rdata <= m_rdata;
          end else begin
            r_d_rdata <= m_rdata;
          end
        end
      end
    end
  end

  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter with a
//               little-endian byte memory behind the shared port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_size;
  logic        d_sign;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_err;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_read;
  logic        m_write;
  logic [1:0]  m_size;
  logic        m_sign;
  logic [31:0] m_rdata;

  // preload port into the memory model
  logic        pl_we;
  logic [9:0]  pl_addr;
  logic [31:0] pl_data;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cycles = 0;
  int rd_cycles = 0;

  mem_arbiter #(.MEM_LATENCY(2), .STARVE_LIMIT(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_ack   (i_ack),
    .i_err   (i_err),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_size  (d_size),
    .d_sign  (d_sign),
    .d_rdata (d_rdata),
    .d_ack   (d_ack),
    .d_err   (d_err),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_read  (m_read),
    .m_write (m_write),
    .m_size  (m_size),
    .m_sign  (m_sign),
    .m_rdata (m_rdata)
  );

  always #5 clk = ~clk;

  // Little-endian byte memory: combinational read, sized write on the edge.
  logic [7:0] mem [0:1023];

  always @(posedge clk) begin
    if (pl_we) begin
      mem[pl_addr]         <= pl_data[7:0];
      mem[pl_addr + 10'd1] <= pl_data[15:8];
      mem[pl_addr + 10'd2] <= pl_data[23:16];
      mem[pl_addr + 10'd3] <= pl_data[31:24];
    end else if (m_write) begin
      mem[m_addr[9:0]] <= m_wdata[7:0];
      if (m_size != 2'b01) mem[m_addr[9:0] + 10'd1] <= m_wdata[15:8];
      if (m_size == 2'b11) begin
        mem[m_addr[9:0] + 10'd2] <= m_wdata[23:16];
        mem[m_addr[9:0] + 10'd3] <= m_wdata[31:24];
      end
    end
  end

  always_comb begin
    logic [7:0] b0, b1, b2, b3;
    b0 = mem[m_addr[9:0]];
    b1 = mem[m_addr[9:0] + 10'd1];
    b2 = mem[m_addr[9:0] + 10'd2];
    b3 = mem[m_addr[9:0] + 10'd3];
    case (m_size)
      2'b01:   m_rdata = {{24{m_sign & b0[7]}}, b0};
      2'b10:   m_rdata = {{16{m_sign & b1[7]}}, b1, b0};
      default: m_rdata = {b3, b2, b1, b0};
    endcase
  end

  // Count memory activity and watch that no request is withdrawn early.
  logic p_i_req = 1'b0, p_i_ack = 1'b0, p_d_req = 1'b0, p_d_ack = 1'b0;
  always @(negedge clk) begin
    if (m_write) wr_cycles++;
    if (m_read)  rd_cycles++;
    if (rst) begin
      p_i_req = 1'b0; p_i_ack = 1'b0; p_d_req = 1'b0; p_d_ack = 1'b0;
    end else begin
      if (p_i_req && !p_i_ack && !i_ack) begin
        n_checks++;
        assert (i_req === 1'b1) else begin
          n_fail++;
          $error("FAIL i_req_dropped: observed %b expected 1", i_req);
        end
      end
      if (p_d_req && !p_d_ack && !d_ack) begin
        n_checks++;
        assert (d_req === 1'b1) else begin
          n_fail++;
          $error("FAIL d_req_dropped: observed %b expected 1", d_req);
        end
      end
      p_i_req = i_req; p_i_ack = i_ack; p_d_req = d_req; p_d_ack = d_ack;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [31:0] fetch_exp [3];
  logic [7:0]  grant_seq [10];
  string       exp_order;
  int          n_grants;
  int          w0, r0;
  logic        seen;

  initial begin
    rst = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
    d_wdata = 0; d_size = 0; d_sign = 0; pl_we = 0; pl_addr = 0; pl_data = 0;
    fetch_exp[0] = 32'hA0000001;
    fetch_exp[1] = 32'hA0000002;
    fetch_exp[2] = 32'hA0000003;
    exp_order = "DDDDIDDDDI";

    // preload program words while reset is held
    for (int k = 0; k < 3; k++) begin
      pl_we = 1; pl_addr = 10'(4 * k); pl_data = fetch_exp[k];
      tick();
    end
    pl_we = 1; pl_addr = 10'h010; pl_data = 32'h24020005;
    tick();
    pl_we = 0;

    // reset state
    check("rst_i_ack", {31'b0, i_ack}, 32'd0);
    check("rst_d_ack", {31'b0, d_ack}, 32'd0);
    check("rst_m_read", {31'b0, m_read}, 32'd0);
    check("rst_m_write", {31'b0, m_write}, 32'd0);
    check("rst_m_addr", m_addr, 32'h0);
    check("rst_i_rdata", i_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    rst = 0;
    tick(); tick();

    // single fetch at 0x10
    i_addr = 32'h10; i_req = 1;
    check("f_idle_m_read", {31'b0, m_read}, 32'd0);
    tick();
    check("f_b1_m_read", {31'b0, m_read}, 32'd1);
    check("f_b1_m_addr", m_addr, 32'h10);
    check("f_b1_m_size", {30'b0, m_size}, 32'd3);
    check("f_b1_i_ack", {31'b0, i_ack}, 32'd0);
    tick();
    check("f_b2_m_read", {31'b0, m_read}, 32'd1);
    check("f_b2_i_ack", {31'b0, i_ack}, 32'd0);
    tick();
    check("f_ack", {31'b0, i_ack}, 32'd1);
    check("f_rdata", i_rdata, 32'h24020005);
    check("f_err", {31'b0, i_err}, 32'd0);
    check("f_ack_m_read", {31'b0, m_read}, 32'd0);
    i_req = 0;
    tick();
    check("f_after_ack", {31'b0, i_ack}, 32'd0);
    check("f_rdata_held", i_rdata, 32'h24020005);

    // store word 0xDEADBEEF to 0x100
    w0 = wr_cycles;
    d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_size = 2'b11; d_sign = 0; d_req = 1;
    tick();
    check("st_b1_m_write", {31'b0, m_write}, 32'd0);
    check("st_b1_m_read", {31'b0, m_read}, 32'd0);
    check("st_b1_m_addr", m_addr, 32'h100);
    check("st_b1_m_wdata", m_wdata, 32'hDEADBEEF);
    tick();
    check("st_b2_m_write", {31'b0, m_write}, 32'd1);
    tick();
    check("st_ack", {31'b0, d_ack}, 32'd1);
    check("st_err", {31'b0, d_err}, 32'd0);
    check("st_ack_m_write", {31'b0, m_write}, 32'd0);
    check("st_d_rdata_unchanged", d_rdata, 32'h0);
    d_req = 0;
    tick();
    check("st_write_cycles", 32'(wr_cycles - w0), 32'd1);

    // load word back
    d_we = 0; d_size = 2'b11; d_req = 1;
    tick(); tick(); tick();
    check("lw_ack", {31'b0, d_ack}, 32'd1);
    check("lw_rdata", d_rdata, 32'hDEADBEEF);
    d_req = 0;
    tick();

    // load byte signed at 0x103
    d_addr = 32'h103; d_size = 2'b01; d_sign = 1; d_req = 1;
    tick(); tick(); tick();
    check("lb_ack", {31'b0, d_ack}, 32'd1);
    check("lb_rdata", d_rdata, 32'hFFFFFFDE);
    d_req = 0;
    tick();

    // misaligned half load at 0x101
    w0 = wr_cycles; r0 = rd_cycles;
    d_addr = 32'h101; d_size = 2'b10; d_sign = 0; d_req = 1;
    tick();
    check("mh_ack", {31'b0, d_ack}, 32'd1);
    check("mh_err", {31'b0, d_err}, 32'd1);
    check("mh_rdata_held", d_rdata, 32'hFFFFFFDE);
    d_req = 0;
    tick();
    check("mh_ack_done", {31'b0, d_ack}, 32'd0);
    check("mh_no_mem", 32'((wr_cycles - w0) + (rd_cycles - r0)), 32'd0);

    // misaligned fetch at 0x102
    i_addr = 32'h102; i_req = 1;
    tick();
    check("mf_ack", {31'b0, i_ack}, 32'd1);
    check("mf_err", {31'b0, i_err}, 32'd1);
    check("mf_rdata_held", i_rdata, 32'h24020005);
    i_req = 0;
    tick();
    check("mf_ack_done", {31'b0, i_ack}, 32'd0);

    // reset during the first busy cycle of a store
    w0 = wr_cycles;
    d_we = 1; d_addr = 32'h200; d_wdata = 32'hCAFEF00D; d_size = 2'b11; d_req = 1;
    tick();
    rst = 1; d_req = 0;
    #1;
    check("rb_m_addr", m_addr, 32'h0);
    check("rb_m_wdata", m_wdata, 32'h0);
    check("rb_m_write", {31'b0, m_write}, 32'd0);
    check("rb_d_rdata", d_rdata, 32'h0);
    check("rb_i_rdata", i_rdata, 32'h0);
    tick();
    rst = 0;
    tick();
    check("rb_no_ack", {31'b0, d_ack}, 32'd0);
    tick();
    check("rb_no_ack2", {31'b0, d_ack}, 32'd0);
    check("rb_no_write", 32'(wr_cycles - w0), 32'd0);

    // reissue the store, then read it back
    d_req = 1;
    tick(); tick(); tick();
    check("rs_ack", {31'b0, d_ack}, 32'd1);
    check("rs_err", {31'b0, d_err}, 32'd0);
    d_req = 0;
    tick();
    d_we = 0; d_req = 1;
    tick(); tick(); tick();
    check("rs_load", d_rdata, 32'hCAFEF00D);
    d_req = 0;
    tick();

    // back-to-back fetches 0x0, 0x4, 0x8: ack every 4 cycles
    i_addr = 32'h0; i_req = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bb_busy1_no_ack", {31'b0, i_ack}, 32'd0);
      tick();
      check("bb_busy2_no_ack", {31'b0, i_ack}, 32'd0);
      tick();
      check("bb_ack", {31'b0, i_ack}, 32'd1);
      check("bb_rdata", i_rdata, fetch_exp[k]);
      check("bb_d_rdata_held", d_rdata, 32'hCAFEF00D);
      if (k < 2) i_addr = 32'(4 * (k + 1));
      else       i_req = 0;
      tick();
      check("bb_idle_no_ack", {31'b0, i_ack}, 32'd0);
    end

    // both requesters held: fetch forced in after four data grants
    d_we = 0; d_addr = 32'h100; d_size = 2'b11; d_sign = 0;
    i_addr = 32'h10;
    i_req = 1; d_req = 1;
    n_grants = 0;
    for (int c = 0; c < 120 && n_grants < 10; c++) begin
      tick();
      if (d_ack) begin grant_seq[n_grants] = 8'h44; n_grants++; end
      else if (i_ack) begin grant_seq[n_grants] = 8'h49; n_grants++; end
    end
    check("grant_count", 32'(n_grants), 32'd10);
    for (int j = 0; j < n_grants; j++) begin
      check($sformatf("grant_%0d", j), {24'b0, grant_seq[j]}, {24'b0, exp_order[j]});
    end
    i_req = 0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (d_ack) seen = 1;
    end
    check("drain_d_ack", {31'b0, seen}, 32'd1);
    d_req = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_mem_arbiter
`default_nettype wire
